// File: rtl/btb_pkg.sv
// Shared types for the BTB update path: counter encodings, queue entry and drain FSM states.
// Optional statistics counters in btb_update_ctrl are enabled with BTB_UPDATE_STATS_EN.
package btb_pkg;

    localparam int unsigned DEFAULT_DEPTH      = 4;
    localparam int unsigned DEFAULT_INDEX_BITS = 6;
    localparam int unsigned ADDR_W             = 32;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } btb_ctr_e;

    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'b00,
        DRAIN_ISSUE = 2'b01,
        DRAIN_DEFER = 2'b10
    } drain_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] target;
        btb_ctr_e          state;
    } btb_entry_t;

    // Counter value to store: misses allocate weakly-taken, hits saturate toward the outcome.
    function automatic btb_ctr_e ctr_update(input logic hit, input logic taken, input btb_ctr_e cur);
        if (!hit) begin
            return CTR_WT;
        end
        if (taken) begin
            return (cur == CTR_ST) ? CTR_ST : btb_ctr_e'(cur + 2'd1);
        end
        return (cur == CTR_SNT) ? CTR_SNT : btb_ctr_e'(cur - 2'd1);
    endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// Circular FIFO of pending BTB updates; a push while full without a pop is dropped
// and reported on drop_o.
module btb_update_fifo
    import btb_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  btb_entry_t data_i,
    input  logic       pop_i,
    output btb_entry_t head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       drop_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    btb_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop_c;
    logic             do_push_c;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_pop_c  = pop_i && !empty_o;
    assign do_push_c = push_i && (!full_o || do_pop_c);
    assign drop_o    = push_i && full_o && !do_pop_c;
    assign head_o    = mem_q[rd_ptr_q];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push_c && !do_pop_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop_c && !do_push_c) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push_c) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// Queues resolved-branch BTB updates, drains them around stalls and read-port index
// conflicts, and raises mispredict redirects. Define BTB_UPDATE_STATS_EN for resolve/mispredict counters.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned INDEX_BITS = DEFAULT_INDEX_BITS
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ResolveValid,
    input  logic [31:0] ResolvePC,
    input  logic [31:0] ResolveTarget,
    input  logic        ResolveTaken,
    input  logic        ResolveHit,
    input  logic [1:0]  ResolveState,
    input  logic [31:0] FetchPC,
    input  logic        Stall,
    output logic        we,
    output logic [31:0] WrPC,
    output logic [31:0] WrTarget,
    output logic [1:0]  WrState,
    output logic        RedirectValid,
    output logic [31:0] RedirectPC,
    output logic        Full,
    output logic        Empty,
    output logic        Overflow
`ifdef BTB_UPDATE_STATS_EN
    ,
    output logic [31:0] ResolveCount,
    output logic [31:0] MispredictCount
`endif
);

    drain_state_e          state_q;
    drain_state_e          state_d;
    btb_entry_t            enq_entry_c;
    btb_entry_t            head_c;
    logic                  enq_c;
    logic                  mispredict_c;
    logic                  eligible_c;
    logic                  issue_c;
    logic                  drop_c;
    logic                  fifo_full_c;
    logic                  fifo_empty_c;
    logic [INDEX_BITS-1:0] head_idx_c;
    logic [INDEX_BITS-1:0] fetch_idx_c;
    logic                  unused_fetch_bits;

    logic                  we_q;
    logic [31:0]           wr_pc_q;
    logic [31:0]           wr_target_q;
    btb_ctr_e              wr_state_q;
    logic                  redirect_valid_q;
    logic [31:0]           redirect_pc_q;
    logic                  overflow_q;

    assign enq_c        = ResolveValid && (ResolveTaken || ResolveHit);
    assign mispredict_c = ResolveValid && ((ResolveHit && ResolveState[1]) != ResolveTaken);
    assign head_idx_c   = head_c.pc[INDEX_BITS+1:2];
    assign fetch_idx_c  = FetchPC[INDEX_BITS+1:2];
    assign eligible_c   = !fifo_empty_c && !Stall && (head_idx_c != fetch_idx_c);
    assign unused_fetch_bits = ^{FetchPC[31:INDEX_BITS+2], FetchPC[1:0]};

    always_comb begin
        enq_entry_c        = '0;
        enq_entry_c.pc     = ResolvePC;
        enq_entry_c.target = ResolveTarget;
        enq_entry_c.state  = ctr_update(ResolveHit, ResolveTaken, btb_ctr_e'(ResolveState));
    end

    btb_update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .push_i  (enq_c),
        .data_i  (enq_entry_c),
        .pop_i   (issue_c),
        .head_o  (head_c),
        .full_o  (fifo_full_c),
        .empty_o (fifo_empty_c),
        .drop_o  (drop_c)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= DRAIN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Any state moves to ISSUE as soon as the head entry may be written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DRAIN_IDLE: begin
                if (eligible_c)         state_d = DRAIN_ISSUE;
                else if (!fifo_empty_c) state_d = DRAIN_DEFER;
            end
            DRAIN_ISSUE: begin
                if (eligible_c)         state_d = DRAIN_ISSUE;
                else if (!fifo_empty_c) state_d = DRAIN_DEFER;
                else                    state_d = DRAIN_IDLE;
            end
            DRAIN_DEFER: begin
                if (eligible_c)        state_d = DRAIN_ISSUE;
                else if (fifo_empty_c) state_d = DRAIN_IDLE;
            end
            default: state_d = DRAIN_IDLE;
        endcase
    end

    // Entering ISSUE pops the head and latches it into the write port.
    always_comb begin
        issue_c = 1'b0;
        if (state_d == DRAIN_ISSUE) begin
            issue_c = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            we_q             <= 1'b0;
            wr_pc_q          <= '0;
            wr_target_q      <= '0;
            wr_state_q       <= CTR_SNT;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            overflow_q       <= 1'b0;
        end else begin
            we_q             <= issue_c;
            redirect_valid_q <= mispredict_c;
            if (issue_c) begin
                wr_pc_q     <= head_c.pc;
                wr_target_q <= head_c.target;
                wr_state_q  <= head_c.state;
            end
            if (mispredict_c) begin
                redirect_pc_q <= ResolveTaken ? ResolveTarget : (ResolvePC + 32'd4);
            end
            if (drop_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign we            = we_q;
    assign WrPC          = wr_pc_q;
    assign WrTarget      = wr_target_q;
    assign WrState       = wr_state_q;
    assign RedirectValid = redirect_valid_q;
    assign RedirectPC    = redirect_pc_q;
    assign Full          = fifo_full_c;
    assign Empty         = fifo_empty_c;
    assign Overflow      = overflow_q;

`ifdef BTB_UPDATE_STATS_EN
    logic [31:0] resolve_cnt_q;
    logic [31:0] mispredict_cnt_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            resolve_cnt_q    <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (ResolveValid) resolve_cnt_q    <= resolve_cnt_q + 32'd1;
            if (mispredict_c) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign ResolveCount    = resolve_cnt_q;
    assign MispredictCount = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_btb_update_ctrl;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        ResolveValid;
    logic [31:0] ResolvePC;
    logic [31:0] ResolveTarget;
    logic        ResolveTaken;
    logic        ResolveHit;
    logic [1:0]  ResolveState;
    logic [31:0] FetchPC;
    logic        Stall;
    logic        we;
    logic [31:0] WrPC;
    logic [31:0] WrTarget;
    logic [1:0]  WrState;
    logic        RedirectValid;
    logic [31:0] RedirectPC;
    logic        Full;
    logic        Empty;
    logic        Overflow;

    always #5 Clk = ~Clk;

    btb_update_ctrl #(.DEPTH(DEPTH), .INDEX_BITS(6)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .ResolveValid  (ResolveValid),
        .ResolvePC     (ResolvePC),
        .ResolveTarget (ResolveTarget),
        .ResolveTaken  (ResolveTaken),
        .ResolveHit    (ResolveHit),
        .ResolveState  (ResolveState),
        .FetchPC       (FetchPC),
        .Stall         (Stall),
        .we            (we),
        .WrPC          (WrPC),
        .WrTarget      (WrTarget),
        .WrState       (WrState),
        .RedirectValid (RedirectValid),
        .RedirectPC    (RedirectPC),
        .Full          (Full),
        .Empty         (Empty),
        .Overflow      (Overflow)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        int          st;
    } ment_t;

    int          checks   = 0;
    int          failures = 0;
    ment_t       mq[$];
    bit          mvalid = 1'b0;
    bit          e_we, e_rv, e_ovf;
    logic [31:0] e_wpc, e_wt, e_rpc;
    int          e_ws;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3F);
    endfunction

    // Reference: one edge of the update path described at queue level.
    task automatic model_step();
        ment_t e;
        int    ns;
        bit    elig;
        bit    mis;
        if (Rst) begin
            mq.delete();
            e_we = 0; e_rv = 0; e_ovf = 0;
            e_wpc = 0; e_wt = 0; e_ws = 0; e_rpc = 0;
            mvalid = 1'b1;
            return;
        end
        elig = (mq.size() > 0) && !Stall && (idx(mq[0].pc) != idx(FetchPC));
        e_we = elig;
        if (elig) begin
            e = mq.pop_front();
            e_wpc = e.pc; e_wt = e.tgt; e_ws = e.st;
        end
        mis  = ResolveValid && (int'(ResolveHit ? ResolveState[1] : 1'b0) != int'(ResolveTaken));
        e_rv = mis;
        if (mis) e_rpc = ResolveTaken ? ResolveTarget : ResolvePC + 32'd4;
        if (ResolveValid && (ResolveTaken || ResolveHit)) begin
            if (!ResolveHit)       ns = 2;
            else if (ResolveTaken) ns = (ResolveState == 2'd3) ? 3 : int'(ResolveState) + 1;
            else                   ns = (ResolveState == 2'd0) ? 0 : int'(ResolveState) - 1;
            if (mq.size() < DEPTH) begin
                e.pc = ResolvePC; e.tgt = ResolveTarget; e.st = ns;
                mq.push_back(e);
            end else begin
                e_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare();
        chk("we", 32'(we), 32'(e_we));
        chk("redirect_valid", 32'(RedirectValid), 32'(e_rv));
        chk("empty", 32'(Empty), 32'(mq.size() == 0));
        chk("full", 32'(Full), 32'(mq.size() == DEPTH));
        chk("overflow", 32'(Overflow), 32'(e_ovf));
        if (e_we) begin
            chk("wr_pc", WrPC, e_wpc);
            chk("wr_target", WrTarget, e_wt);
            chk("wr_state", 32'(WrState), 32'(e_ws));
        end
        if (e_rv) chk("redirect_pc", RedirectPC, e_rpc);
    endtask

    // Compare at negedge, advance model at posedge, leave inputs free to change at +1.
    task automatic tick();
        @(negedge Clk);
        if (mvalid) compare();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic hit, input logic [1:0] st);
        ResolveValid = 1'b1; ResolvePC = pc; ResolveTarget = tgt;
        ResolveTaken = tk; ResolveHit = hit; ResolveState = st;
    endtask

    task automatic idle();
        ResolveValid = 1'b0;
    endtask

    int unsigned stall_pct;

    initial begin
        Rst = 1'b1; Stall = 1'b0; FetchPC = 32'h0000_0FFC;
        ResolveValid = 1'b0; ResolvePC = '0; ResolveTarget = '0;
        ResolveTaken = 1'b0; ResolveHit = 1'b0; ResolveState = '0;
        tick(); tick();
        Rst = 1'b0;
        chk("rst_we", 32'(we), 0);
        chk("rst_rv", 32'(RedirectValid), 0);
        chk("rst_rpc", RedirectPC, 0);
        chk("rst_wrpc", WrPC, 0);
        chk("rst_wrtgt", WrTarget, 0);
        chk("rst_wrstate", 32'(WrState), 0);
        chk("rst_empty", 32'(Empty), 1);
        chk("rst_full", 32'(Full), 0);
        chk("rst_ovf", 32'(Overflow), 0);

        // Taken miss from idle.
        resolve(32'h40, 32'h80, 1'b1, 1'b0, 2'd0); tick(); idle();
        chk("m38_rv", 32'(RedirectValid), 1);
        chk("m38_rpc", RedirectPC, 32'h80);
        chk("m38_we_early", 32'(we), 0);
        tick();
        chk("m38_we", 32'(we), 1);
        chk("m38_wrstate", 32'(WrState), 2);
        chk("m38_wrpc", WrPC, 32'h40);
        chk("m38_wrtgt", WrTarget, 32'h80);
        tick();
        chk("m38_we_done", 32'(we), 0);
        chk("m38_empty", 32'(Empty), 1);

        // Strongly-taken hit resolves not taken.
        resolve(32'h100, 32'h500, 1'b0, 1'b1, 2'd3); tick(); idle();
        chk("m39_rv", 32'(RedirectValid), 1);
        chk("m39_rpc", RedirectPC, 32'h104);
        tick();
        chk("m39_we", 32'(we), 1);
        chk("m39_wrstate", 32'(WrState), 2);
        chk("m39_wrpc", WrPC, 32'h100);
        tick();

        // Read-port index conflict holds the write.
        FetchPC = 32'h200;
        resolve(32'h200, 32'h600, 1'b1, 1'b0, 2'd0); tick(); idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("m40_defer_we", 32'(we), 0);
        end
        FetchPC = 32'h0000_0FFC;
        tick();
        chk("m40_we", 32'(we), 1);
        chk("m40_wrpc", WrPC, 32'h200);
        tick();

        // Stall fills the queue and drops the fifth entry.
        Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            resolve(32'h300 + 32'(4 * i), 32'h700 + 32'(4 * i), 1'b1, 1'b0, 2'd0);
            tick();
            if (i == 3) begin
                chk("m41_full4", 32'(Full), 1);
                chk("m41_noovf4", 32'(Overflow), 0);
            end
        end
        idle();
        chk("m41_ovf", 32'(Overflow), 1);
        Stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("m41_we", 32'(we), 1);
            chk("m41_order", WrPC, 32'h300 + 32'(4 * i));
        end
        tick();
        chk("m41_empty", 32'(Empty), 1);
        chk("m41_ovf_sticky", 32'(Overflow), 1);

        // Push into a full queue on the same edge as a pop.
        Rst = 1'b1; tick(); Rst = 1'b0;
        Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            resolve(32'h400 + 32'(4 * i), 32'h800 + 32'(4 * i), 1'b1, 1'b1, 2'd1);
            tick();
        end
        chk("m42_full", 32'(Full), 1);
        Stall = 1'b0;
        resolve(32'h480, 32'h880, 1'b1, 1'b0, 2'd0); tick(); idle();
        chk("m42_we", 32'(we), 1);
        chk("m42_wrpc", WrPC, 32'h400);
        chk("m42_still_full", 32'(Full), 1);
        chk("m42_noovf", 32'(Overflow), 0);
        for (int i = 0; i < 4; i++) tick();
        chk("m42_last_pc", WrPC, 32'h480);
        chk("m42_last_state", 32'(WrState), 2);
        tick();
        chk("m42_empty", 32'(Empty), 1);

        // Reset with entries pending.
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            resolve(32'h500 + 32'(4 * i), 32'h900, 1'b1, 1'b0, 2'd0);
            tick();
        end
        idle(); Stall = 1'b0; Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("m43_empty", 32'(Empty), 1);
        chk("m43_we", 32'(we), 0);
        chk("m43_rv", 32'(RedirectValid), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("m43_no_we", 32'(we), 0);
        end

        // Randomized traffic against the model.
        stall_pct = 20;
        for (int c = 0; c < 4000; c++) begin
            if ((c % 400) == 0) stall_pct = $urandom_range(0, 80);
            Rst          = ($urandom_range(0, 299) == 0);
            Stall        = ($urandom_range(0, 99) < stall_pct);
            ResolveValid = ($urandom_range(0, 9) < 6);
            ResolveTaken = $urandom_range(0, 1) == 1;
            ResolveHit   = $urandom_range(0, 1) == 1;
            ResolveState = 2'($urandom_range(0, 3));
            ResolvePC    = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 49) == 0) ResolvePC = 32'hFFFF_FFFC;
            ResolveTarget = $urandom & 32'hFFFF_FFFC;
            FetchPC       = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 3)) << 2);
            tick();
        end
        Rst = 1'b0; idle(); Stall = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 Parameter DEPTH, default 4: update queue entries; power of two, 2..16.
REQ-002 Parameter INDEX_BITS, default 6: BTB index width; index = PC[INDEX_BITS+1:2].
REQ-003 Clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Rst  in  1  reset; synchronous, active-high.
REQ-005 ResolveValid  in  1  branch resolved in ID this cycle.
REQ-006 ResolvePC  in  32  address of resolved branch.
REQ-007 ResolveTarget  in  32  computed branch target.
REQ-008 ResolveTaken  in  1  actual outcome.
REQ-009 ResolveHit  in  1  branch was found in BTB at fetch.
REQ-010 ResolveState  in  2  2-bit counter value read at fetch (valid when ResolveHit).
REQ-011 FetchPC  in  32  current fetch address; its index occupies the BTB read port.
REQ-012 Stall  in  1  pipeline stall; BTB writes forbidden while high.
REQ-013 we  out  1  BTB write strobe.
REQ-014 WrPC / WrTarget  out  32 each  BTB write tag and target.
REQ-015 WrState  out  2  counter value to write.
REQ-016 RedirectValid  out  1  one-cycle mispredict redirect pulse.
REQ-017 RedirectPC  out  32  recovery fetch address.
REQ-018 Full / Empty  out  1 each  queue status.
REQ-019 Overflow  out  1  sticky flag: a resolve was dropped.

Function
REQ-020 Enqueue condition: ResolveValid and (ResolveTaken or ResolveHit); not-taken misses SHALL NOT enqueue.
REQ-021 New state at enqueue: hit -> saturating counter (taken: +1, max 11; not taken: -1, min 00); miss -> 10 (weakly taken).
REQ-022 Mispredict = ResolveValid and (hit ? ResolveState[1] : 0) != ResolveTaken; RedirectValid SHALL pulse exactly one cycle after.
REQ-023 RedirectPC = ResolveTarget if taken, else ResolvePC+4 (mod 2^32), registered with RedirectValid.
REQ-024 Queue: FIFO, DEPTH entries {PC, Target, State}; pointers wrap modulo DEPTH.
REQ-025 Drain FSM states: IDLE, ISSUE, DEFER.
REQ-026 IDLE -> ISSUE when not Empty and not Stall and head index != FetchPC index.
REQ-027 IDLE -> DEFER when not Empty and (Stall or index conflict); DEFER -> ISSUE when both clear; we stays low in DEFER.
REQ-028 ISSUE: we high exactly one cycle with head fields; head popped same edge; next state ISSUE if eligible again, else DEFER if not Empty, else IDLE.
REQ-029 Enqueue-to-we latency, empty queue, no stall/conflict: 2 cycles.
REQ-030 Simultaneous enqueue and pop when Full: both occur; no drop.
REQ-031 Enqueue when Full without pop: entry dropped, Overflow set, queue unchanged.
REQ-032 Enqueue of PC equal to queued entry: appended; later write wins (no merge).

Reset
REQ-033 Rst high: pointers 0, FSM IDLE, we 0, RedirectValid 0, RedirectPC 0, Wr* 0, Empty 1, Full 0, Overflow 0.
REQ-034 Rst mid-drain SHALL discard all queued entries and suppress any pending we/redirect that cycle.

Configuration
REQ-035 Macro BTB_UPDATE_STATS_EN: defined -> outputs ResolveCount, MispredictCount (32 bit each, wrapping, cleared by Rst); undefined -> ports and counters absent, all else identical.

Structure
REQ-036 Package btb_pkg holds counter encodings (SNT 00, WNT 01, WT 10, ST 11), default DEPTH and INDEX_BITS, queue entry struct.
REQ-037 FIFO SHALL be sub-module btb_update_fifo; FSM, counter update and redirect logic in top.

Verification
REQ-038 Miss, taken, PC 0x40, target 0x80, idle -> RedirectValid next cycle, RedirectPC 0x80; we 2 cycles later, WrState 10.
REQ-039 Hit, state 11, not taken, PC 0x100 -> RedirectPC 0x104, WrState 10.
REQ-040 Queued PC 0x200 with FetchPC 0x200 held 3 cycles -> FSM DEFER, we low; we fires cycle after FetchPC changes.
REQ-041 Stall high, 5 enqueues, DEPTH 4 -> Full after 4, Overflow set, 4 writes in order after Stall drops.
REQ-042 Full queue, enqueue same cycle as ISSUE -> no Overflow, count stays 4.
REQ-043 Rst asserted with 3 queued entries -> Empty 1 next cycle, no we afterwards.
